// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_pkg
// Description : Shared types and default sizing for the accumulator
//               scheduler (acc_sched) and its round-robin arbiter.
// Contents    : state_t   - scheduler FSM state encoding
//               c_DEF_*   - default N_REQ / WIDTH / CNT_W values
//               idx_w()   - index width for an N-entry vector (min 1 bit)
// Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

    localparam int c_DEF_N_REQ = 4;
    localparam int c_DEF_WIDTH = 16;
    localparam int c_DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // A single-requester build still needs a 1-bit id field.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Search starts at the
//               requester after i_last_grant and wraps around.
// Ports       : i_req        - request vector
//               i_last_grant - index of the most recently served requester
//               o_grant_oh   - one-hot grant
//               o_grant_idx  - binary grant index
//               o_grant_vld  - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [N_REQ-1:0] o_grant_oh,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_vld
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        w_cand      = '0;
        // Offset 1..N_REQ so the last winner is considered last.
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((int'(i_last_grant) + k) % N_REQ);
            if (!o_grant_vld && i_req[w_cand]) begin
                o_grant_vld        = 1'b1;
                o_grant_idx        = w_cand;
                o_grant_oh[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/acc_sched.sv
`default_nettype none
// ============================================================================
// Module      : acc_sched
// Description : Shares one external registered accumulator among N_REQ
//               packet streams. One packet owns the accumulator at a time;
//               its sum is recovered as (acc_sum - base) so the accumulator
//               never needs clearing and wrap-around is harmless.
// Ports       : clk, rst (async, active-low)
//               req_valid/req_data/req_last/req_ready - per-requester beats
//               acc_in  - accumulator input, acc_sum - accumulator output
//               res_valid/res_ready/res_id/res_sum/res_beats - result
// Revision    : 1.0 - initial release
// ============================================================================
module acc_sched
    import acc_pkg::*;
#(
    parameter int  N_REQ = c_DEF_N_REQ,
    parameter int  WIDTH = c_DEF_WIDTH,
    parameter int  CNT_W = c_DEF_CNT_W,
    localparam int ID_W  = idx_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       acc_in,
    input  logic [WIDTH-1:0]       acc_sum,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [WIDTH-1:0]       res_sum,
    output logic [CNT_W-1:0]       res_beats
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_grant;
    logic [N_REQ-1:0]   r_grant_oh;
    logic [ID_W-1:0]    r_last_grant;
    logic [WIDTH-1:0]   r_base;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_res_sum;
    logic [ID_W-1:0]    r_res_id;
    logic [CNT_W-1:0]   r_res_beats;

    logic [N_REQ-1:0]   w_arb_oh;
    logic [ID_W-1:0]    w_arb_idx;
    logic               w_arb_vld;
    logic               w_beat_vld;
    logic               w_beat_last;
    logic [WIDTH-1:0]   w_beat_data;
    logic               w_accept;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant_oh   (w_arb_oh),
        .o_grant_idx  (w_arb_idx),
        .o_grant_vld  (w_arb_vld)
    );

    assign w_beat_vld  = req_valid[r_grant];
    assign w_beat_last = req_last[r_grant];
    assign w_beat_data = req_data[int'(r_grant)*WIDTH +: WIDTH];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and accumulator/handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        acc_in      = '0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arb_vld) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                req_ready = r_grant_oh;
                if (w_beat_vld) begin
                    acc_in   = w_beat_data;
                    w_accept = 1'b1;
                    if (w_beat_last) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            // Accumulator is registered: the last beat lands in acc_sum
            // one cycle after acceptance.
            S_DRAIN: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant, base capture, beat count and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant      <= '0;
            r_grant_oh   <= '0;
            r_last_grant <= ID_W'(N_REQ - 1);
            r_base       <= '0;
            r_count      <= '0;
            r_res_sum    <= '0;
            r_res_id     <= '0;
            r_res_beats  <= '0;
        end else begin
            if (r_state == S_IDLE && w_arb_vld) begin
                r_grant    <= w_arb_idx;
                r_grant_oh <= w_arb_oh;
                r_base     <= acc_sum;
                r_count    <= '0;
            end
            if (w_accept && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
            if (r_state == S_DRAIN) begin
                r_res_sum   <= acc_sum - r_base;
                r_res_id    <= r_grant;
                r_res_beats <= r_count;
            end
            if (r_state == S_RESP && res_ready) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign res_valid = (r_state == S_RESP);
    assign res_id    = r_res_id;
    assign res_sum   = r_res_sum;
    assign res_beats = r_res_beats;

endmodule
`default_nettype wire

// File: tb/tb_acc_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_sched
// Description : Self-checking bench for acc_sched with a behavioural
//               accumulator, packet-level scoreboard, directed vector
//               table, multi-cycle corner sequences and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_sched;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int C   = 8;
    localparam int IW  = 2;
    localparam int SAT = (1 << C) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   acc_in;
    logic [W-1:0]   acc_sum = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [IW-1:0]  res_id;
    logic [W-1:0]   res_sum;
    logic [C-1:0]   res_beats;
    logic           preload = 1'b0;
    logic [W-1:0]   preload_val = '0;

    acc_sched #(.N_REQ(N), .WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .acc_in    (acc_in),
        .acc_sum   (acc_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_beats (res_beats)
    );

    always #5 clk = ~clk;

    // External accumulator: sum <= sum + in, with a preload hook
    always @(posedge clk) acc_sum <= preload ? preload_val : acc_sum + acc_in;

    int tests = 0;
    int fails = 0;

    // Per-requester beat queues: [W+1]=bubble slot, [W]=last, [W-1:0]=data
    logic [W+1:0] beatq [N][$];
    logic [W-1:0] sq    [N][$];   // expected packet sums
    int           cq    [N][$];   // expected (saturated) beat counts
    logic [W-1:0] pk_sum [N];
    int           pk_n   [N];
    int           res_log [$];
    int           lr_id, lr_beats;
    logic [W-1:0] lr_sum;

    // Packet-level reference: phase 0 idle, 1 streaming, 2 landing, 3 result
    int m_phase = 0;
    int m_last  = N - 1;
    int m_w     = 0;
    int bubble_pct = 0;
    int rr_pct     = 100;

    typedef struct {
        int               req;
        int               n;
        logic [3:0][W-1:0] d;
        int               gap;
        bit               pre;
        logic [W-1:0]     pre_val;
        int               exp_id;
        logic [W-1:0]     exp_sum;
        int               exp_beats;
    } vec_t;
    vec_t vt [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    task automatic push_beat(input int r, input logic [W-1:0] d, input bit last);
        beatq[r].push_back({1'b0, last, d});
        pk_sum[r] = pk_sum[r] + d;
        pk_n[r]++;
        if (last) begin
            sq[r].push_back(pk_sum[r]);
            cq[r].push_back((pk_n[r] > SAT) ? SAT : pk_n[r]);
            pk_sum[r] = '0;
            pk_n[r]   = 0;
        end
    endtask

    task automatic push_bubble(input int r);
        logic [W+1:0] e;
        e = '0;
        e[W+1] = 1'b1;
        beatq[r].push_back(e);
    endtask

    // One clock cycle: drive at negedge, check 1ns later, advance.
    task automatic step();
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] exp_acc;
        bit           exp_rv;
        int           nxt;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = W'($urandom);
            req_last[i]  = 1'($urandom_range(1, 0));
            req_valid[i] = 1'b0;
            if (beatq[i].size() > 0 && !beatq[i][0][W+1] &&
                $urandom_range(99, 0) >= bubble_pct) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = beatq[i][0][W-1:0];
                req_last[i]        = beatq[i][0][W];
            end
        end
        res_ready = ($urandom_range(99, 0) < rr_pct);
        #1;
        v = req_valid;
        exp_rdy = '0;
        exp_acc = '0;
        exp_rv  = 1'b0;
        nxt     = m_phase;
        case (m_phase)
            0: if (|v) begin m_w = rr_pick(m_last, v); nxt = 1; end
            1: begin
                exp_rdy[m_w] = 1'b1;
                if (v[m_w]) begin
                    exp_acc = req_data[m_w*W +: W];
                    if (req_last[m_w]) nxt = 2;
                end
            end
            2: nxt = 3;
            default: begin
                exp_rv = 1'b1;
                if (res_ready) begin m_last = m_w; nxt = 0; end
            end
        endcase
        chk("req_ready", req_ready, exp_rdy);
        chk("acc_in", acc_in, exp_acc);
        chk("res_valid", res_valid, exp_rv);
        if (exp_rv) begin
            chk("res_id", res_id, m_w);
            if (sq[m_w].size() == 0) begin
                chk("res_unexpected", 1, 0);
            end else begin
                chk("res_sum", res_sum, sq[m_w][0]);
                chk("res_beats", res_beats, cq[m_w][0]);
                if (res_ready) begin
                    void'(sq[m_w].pop_front());
                    void'(cq[m_w].pop_front());
                    res_log.push_back(m_w);
                    lr_id = int'(res_id); lr_sum = res_sum; lr_beats = int'(res_beats);
                end
            end
        end
        if (m_phase == 1 && v[m_w]) void'(beatq[m_w].pop_front());
        for (int i = 0; i < N; i++) begin
            if (beatq[i].size() > 0 && beatq[i][0][W+1]) void'(beatq[i].pop_front());
        end
        m_phase = nxt;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until(input int target, input int budget);
        int cyc = 0;
        while (res_log.size() < target && cyc < budget) begin
            step();
            cyc++;
        end
        if (res_log.size() < target) begin
            tests++;
            fails++;
            $display("FAIL timeout: results %0d expected %0d", res_log.size(), target);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_acc_in", acc_in, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_beats", res_beats, 0);
        for (int i = 0; i < N; i++) begin
            beatq[i].delete(); sq[i].delete(); cq[i].delete();
            pk_sum[i] = '0; pk_n[i] = 0;
        end
        m_phase = 0;
        m_last  = N - 1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic preload_acc(input logic [W-1:0] val);
        req_valid   = '0;
        preload_val = val;
        preload     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        preload     = 1'b0;
    endtask

    task automatic set_vec(input int k, input int r, input int n, input logic [3:0][W-1:0] d,
                           input int gap, input bit pre, input logic [W-1:0] pv,
                           input int eid, input logic [W-1:0] es, input int eb);
        vt[k].req = r; vt[k].n = n; vt[k].d = d; vt[k].gap = gap;
        vt[k].pre = pre; vt[k].pre_val = pv;
        vt[k].exp_id = eid; vt[k].exp_sum = es; vt[k].exp_beats = eb;
    endtask

    initial begin
        int n0;
        int cyc;
        int pend;
        for (int i = 0; i < N; i++) begin pk_sum[i] = '0; pk_n[i] = 0; end

        set_vec(0, 0, 3, {16'h0000, 16'h0007, 16'h0005, 16'h0003}, 0, 1'b0, 16'h0000, 0, 16'd15, 3);
        set_vec(1, 2, 1, {16'h0000, 16'h0000, 16'h0000, 16'h0020}, 0, 1'b1, 16'hFFF0, 2, 16'h0020, 1);
        set_vec(2, 2, 2, {16'h0000, 16'h0000, 16'd20,   16'd10},   2, 1'b0, 16'h0000, 2, 16'd30, 2);
        set_vec(3, 3, 2, {16'h0000, 16'h0000, 16'h0002, 16'hFFFF}, 0, 1'b0, 16'h0000, 3, 16'h0001, 2);
        set_vec(4, 1, 4, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1, 1'b0, 16'h0000, 1, 16'd10, 4);

        #2;
        do_reset();

        // Directed vectors
        for (int k = 0; k < 5; k++) begin
            if (vt[k].pre) preload_acc(vt[k].pre_val);
            n0 = res_log.size();
            for (int b = 0; b < vt[k].n; b++) begin
                push_beat(vt[k].req, vt[k].d[b], b == vt[k].n - 1);
                if (b == 0) for (int g = 0; g < vt[k].gap; g++) push_bubble(vt[k].req);
            end
            run_until(n0 + 1, 60);
            chk("vec_id", lr_id, vt[k].exp_id);
            chk("vec_sum", lr_sum, vt[k].exp_sum);
            chk("vec_beats", lr_beats, vt[k].exp_beats);
        end

        // Round-robin rotation between requesters 1 and 3 after reset
        do_reset();
        push_beat(1, 16'h0011, 1'b1); push_beat(1, 16'h0012, 1'b1);
        push_beat(3, 16'h0031, 1'b1); push_beat(3, 16'h0032, 1'b1);
        n0 = res_log.size();
        run_until(n0 + 4, 80);
        if (res_log.size() >= n0 + 3) begin
            chk("rot_first", res_log[n0], 1);
            chk("rot_second", res_log[n0+1], 3);
            chk("rot_third", res_log[n0+2], 1);
        end

        // Result back-pressure: held 5 cycles, requester 1 must wait
        rr_pct = 0;
        push_beat(0, 16'h0001, 1'b0); push_beat(0, 16'h0002, 1'b1);
        push_beat(1, 16'h0004, 1'b1);
        n0 = res_log.size();
        cyc = 0;
        while (m_phase != 3 && cyc < 20) begin step(); cyc++; end
        chk("hold_reached_resp", m_phase, 3);
        repeat (5) step();
        rr_pct = 100;
        run_until(n0 + 2, 40);
        if (res_log.size() >= n0 + 2) begin
            chk("hold_first", res_log[n0], 0);
            chk("hold_second", res_log[n0+1], 1);
        end

        // Beat-count saturation
        for (int b = 0; b < 260; b++) push_beat(2, 16'h0001, b == 259);
        n0 = res_log.size();
        run_until(n0 + 1, 400);
        chk("sat_beats", lr_beats, SAT);
        chk("sat_sum", lr_sum, 16'd260);

        // Reset in the middle of a packet after two beats
        push_beat(0, 16'd1, 1'b0); push_beat(0, 16'd2, 1'b0);
        push_beat(0, 16'd3, 1'b0); push_beat(0, 16'd4, 1'b1);
        cyc = 0;
        while (beatq[0].size() > 2 && cyc < 10) begin step(); cyc++; end
        n0 = res_log.size();
        do_reset();
        chk("rst_no_result", res_log.size(), n0);
        push_beat(1, 16'd5, 1'b1);
        push_beat(0, 16'd6, 1'b1);
        run_until(n0 + 1, 30);
        chk("rst_first_grant", lr_id, 0);
        chk("rst_first_sum", lr_sum, 16'd6);

        // Random traffic
        bubble_pct = 20;
        rr_pct     = 60;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (beatq[i].size() == 0 && $urandom_range(9, 0) == 0) begin
                    int n;
                    n = $urandom_range(5, 1);
                    for (int b = 0; b < n; b++) push_beat(i, W'($urandom), b == n - 1);
                end
            end
            step();
        end
        bubble_pct = 0;
        rr_pct     = 100;
        cyc = 0;
        pend = 1;
        while (pend != 0 && cyc < 300) begin
            pend = (m_phase != 0) ? 1 : 0;
            for (int i = 0; i < N; i++) pend += beatq[i].size() + sq[i].size();
            if (pend != 0) step();
            cyc++;
        end
        chk("random_drain", pend, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
